// File: rtl/adc_pkg.sv
// Shared constants and types for the 5-stage, decimate-by-64 CIC ADC back-end.
package adc_pkg;

  localparam int unsigned IN_W      = 5;
  localparam int unsigned N_STAGES  = 5;
  // Must be a power of two: the decimation counter relies on natural wrap.
  localparam int unsigned DEC_RATIO = 64;
  localparam int unsigned CNT_W     = $clog2(DEC_RATIO);
  localparam int unsigned OUT_W     = IN_W + N_STAGES * CNT_W;

  typedef logic signed [OUT_W-1:0] cic_word_t;

  function automatic cic_word_t sext(input logic [IN_W-1:0] x);
    return {{(OUT_W - IN_W){x[IN_W-1]}}, x};
  endfunction

endpackage

// File: rtl/cic_integrator.sv
// Single CIC integrator stage: free-running modulo-2^OUT_W accumulator.
module cic_integrator
  import adc_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic [OUT_W-1:0] din,
  output logic [OUT_W-1:0] acc
);

  // Wrap-around is intentional; the comb section recovers the exact result.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) acc <= '0;
    else       acc <= acc + din;
  end

endmodule

// File: rtl/adc_top.sv
// Decimating 5-stage CIC filter (R=64, M=1) for a 5-bit sigma-delta stream.
// Optional input register enabled by defining ADC_INPUT_REG_EN.
module adc_top
  import adc_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic [IN_W-1:0]  dat_in,
  output logic [OUT_W-1:0] dat_out,
  output logic             clk_vld_out
);

  logic [IN_W-1:0]  sample;
  logic [CNT_W-1:0] cnt;
  logic             dec_en;
  cic_word_t        integ [N_STAGES+1];
  cic_word_t        comb  [N_STAGES+1];
  cic_word_t        dly   [N_STAGES];

`ifdef ADC_INPUT_REG_EN
  logic [IN_W-1:0] din_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) din_q <= '0;
    else       din_q <= dat_in;
  end

  assign sample = din_q;
`else
  assign sample = dat_in;
`endif

  assign integ[0] = sext(sample);

  for (genvar k = 0; k < N_STAGES; k++) begin : g_integ
    cic_integrator u_integ (
      .clk  (clk),
      .rstn (rstn),
      .din  (integ[k]),
      .acc  (integ[k+1])
    );
  end

  // Comb stages are evaluated from registered state; delays update only on dec_en.
  assign comb[0] = integ[N_STAGES];

  for (genvar k = 0; k < N_STAGES; k++) begin : g_comb
    assign comb[k+1] = comb[k] - dly[k];

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)       dly[k] <= '0;
      else if (dec_en) dly[k] <= comb[k];
    end
  end

  assign dec_en = (cnt == CNT_W'(DEC_RATIO - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt         <= '0;
      dat_out     <= '0;
      clk_vld_out <= 1'b0;
    end else begin
      cnt         <= cnt + 1'b1;
      clk_vld_out <= dec_en;
      if (dec_en) dat_out <= comb[N_STAGES];
    end
  end

endmodule

// File: tb/tb_adc_top.sv
// Directed self-checking bench for adc_top (works with or without ADC_INPUT_REG_EN).
module tb_adc_top;

  logic        clk = 1'b0;
  logic        rstn;
  logic [4:0]  dat_in;
  logic [34:0] dat_out;
  logic        clk_vld_out;

  int total = 0;
  int bad   = 0;
  bit alt   = 1'b0;

  always #5 clk = ~clk;

  adc_top dut (
    .clk         (clk),
    .rstn        (rstn),
    .dat_in      (dat_in),
    .dat_out     (dat_out),
    .clk_vld_out (clk_vld_out)
  );

  function automatic longint sout();
    logic signed [34:0] s;
    s = dat_out;
    return longint'(s);
  endfunction

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Counts rising edges until clk_vld_out is seen; toggles +7/-7 when alt is set.
  task automatic wait_pulse(output int edges, output longint val);
    edges = -1;
    val   = 0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      if (alt) dat_in = (dat_in == 5'd7) ? 5'h19 : 5'd7;
      if (clk_vld_out) begin
        edges = i;
        val   = sout();
        return;
      end
    end
    chk("pulse_timeout", edges, 64);
  endtask

  task automatic do_reset(input logic [4:0] din);
    alt = 1'b0;
    @(negedge clk);
    rstn   = 1'b0;
    dat_in = din;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
  endtask

  localparam longint P30 = longint'(1) << 30;

  int     e;
  longint v, prev;

  initial begin
    rstn   = 1'b0;
    dat_in = '0;

    // Reset held with random input
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      dat_in = 5'($urandom_range(0, 31));
      @(posedge clk);
      #2;
      chk("rst_dout", sout(), 0);
      chk("rst_vld", longint'(clk_vld_out), 0);
    end

    // Release with DC +1: pulse phase, width, period, ramp and settle
    @(negedge clk);
    dat_in = 5'd1;
    rstn   = 1'b1;
    wait_pulse(e, v);
    chk("first_pulse_edges", e, 64);
    @(posedge clk);
    #1;
    chk("pulse_width", longint'(clk_vld_out), 0);
    prev = v;
    wait_pulse(e, v);
    chk("period_2", e + 1, 64);
    chk("dc1_mono", (v >= prev) ? 1 : 0, 1);
    prev = v;
    for (int k = 3; k <= 10; k++) begin
      wait_pulse(e, v);
      chk("period", e, 64);
      chk("dc1_mono", (v >= prev) ? 1 : 0, 1);
      if (k >= 7) chk("dc1_settle", v, P30);
      prev = v;
    end

    // DC -16: most negative representable output
    do_reset(5'h10);
    for (int k = 1; k <= 8; k++) begin
      wait_pulse(e, v);
      if (k >= 7) chk("dc_m16", v, -(longint'(1) << 34));
    end

    // DC +15
    do_reset(5'h0F);
    for (int k = 1; k <= 8; k++) begin
      wait_pulse(e, v);
      if (k >= 7) chk("dc_p15", v, 15 * P30);
    end
    chk("dc_p15_hist", (sout() != 0) ? 1 : 0, 1);

    // Zero input after +15 history must return to exactly 0
    dat_in = 5'd0;
    for (int k = 1; k <= 8; k++) begin
      wait_pulse(e, v);
      if (k >= 7) chk("zero_return", v, 0);
    end

    // Alternating +7/-7
    do_reset(5'd7);
    alt = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      wait_pulse(e, v);
      if (k >= 7) chk("alt_bound", (v <= 7 * (longint'(1) << 24) && v >= -7 * (longint'(1) << 24)) ? 1 : 0, 1);
    end
    alt = 1'b0;

    // Mid-run asynchronous reset
    do_reset(5'd1);
    repeat (500) @(posedge clk);
    #3;
    chk("pre_rst_nonzero", (sout() != 0) ? 1 : 0, 1);
    rstn = 1'b0;
    #1;
    chk("midrst_dout", sout(), 0);
    chk("midrst_vld", longint'(clk_vld_out), 0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    wait_pulse(e, v);
    chk("midrst_first_pulse", e, 64);
    for (int k = 2; k <= 7; k++) wait_pulse(e, v);
    chk("midrst_settle", v, P30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
